// File: rtl/piano_pkg.sv
// Shared note encoding and recorder state type for the piano datapath.
// Both the recorder (writer) and the player (reader) agree on this layout.
package piano_pkg;

    localparam int NOTE_W = 5;
    localparam int IDX_W  = 3;

    localparam logic [NOTE_W-1:0] NOTE_REST = 5'b0;

    localparam logic [1:0] PITCH_LOW  = 2'b01;
    localparam logic [1:0] PITCH_MID  = 2'b00;
    localparam logic [1:0] PITCH_HIGH = 2'b10;

    // Stored note: pitch in the top two bits, 1..7 = do..si below, 0 = rest.
    typedef struct packed {
        logic [1:0]       pitch;
        logic [IDX_W-1:0] idx;
    } note_t;

    typedef enum logic [1:0] {IDLE, ARM, REC, DONE} rec_state_t;

    // The unused pitch code 11 plays as middle.
    function automatic logic [1:0] norm_pitch(input logic [1:0] p);
        return (p == 2'b11) ? PITCH_MID : p;
    endfunction

endpackage

// File: rtl/rec_ram.sv
// Song buffer: one write port, one registered read port, read-first.
// A cleared read strobe forces the read register to zero.
module rec_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int W     = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_valid,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; song_len alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // NOTE: non-blocking assignments give read-first: a same-cycle write lands after this read.
    always_ff @(posedge clk) begin
        if (!rst_n)        rd_data <= '0;
        else if (rd_valid) rd_data <= mem[rd_addr];
        else               rd_data <= '0;
    end

endmodule

// File: rtl/note_recorder.sv
// Records key/pitch input, sampled on tick, as {note, duration} entries
// and serves them back through a registered read port for auto-play.
module note_recorder
    import piano_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DUR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             rec_start,
    input  logic             rec_stop,
    input  logic [6:0]       key,
    input  logic [1:0]       pitch,
    input  logic [AW-1:0]    rd_addr,
    output logic [4:0]       rd_note,
    output logic [DUR_W-1:0] rd_dur,
    output logic [AW:0]      song_len,
    output logic             recording,
    output logic             full
);

    localparam int W = NOTE_W + DUR_W;

    rec_state_t       state;
    note_t            cur_note;
    logic [DUR_W-1:0] dur;
    logic [AW-1:0]    wr_ptr;

    note_t          s_note;
    logic [2:0]     idx;
    logic           sat;
    logic           wr_en;
    logic           wr_last;
    logic           rd_valid;
    logic [W-1:0]   rd_data;

    // Lowest pressed key wins; scanning downward leaves the lowest set bit last.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        idx = '0;
        for (int i = 6; i >= 0; i--) begin
            if (key[i]) idx = 3'(i + 1);
        end
        s_note.idx   = idx;
        s_note.pitch = (idx == '0) ? PITCH_MID : norm_pitch(pitch);

        sat   = (dur == {DUR_W{1'b1}});
        wr_en = 1'b0;
        if (state == REC) begin
            if (rec_stop)       wr_en = (cur_note != NOTE_REST);
            else if (rec_start) wr_en = 1'b0;
            else if (tick)      wr_en = (s_note != cur_note) || sat;
        end
        wr_last  = wr_en && (wr_ptr == AW'(DEPTH - 1));
        rd_valid = ({1'b0, rd_addr} < song_len);
    end

    // Priority: rec_stop, then rec_start, then tick sampling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_note  <= '0;
            dur       <= '0;
            wr_ptr    <= '0;
            song_len  <= '0;
            recording <= 1'b0;
            full      <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr   <= wr_ptr + 1'b1;
                song_len <= song_len + 1'b1;
            end

            if (rec_stop) begin
                if (state == ARM) begin
                    state     <= DONE;
                    song_len  <= '0;
                    recording <= 1'b0;
                end else if (state == REC) begin
                    state     <= DONE;
                    recording <= 1'b0;
                    if (wr_last) full <= 1'b1;
                end
            end else if (rec_start) begin
                state     <= ARM;
                wr_ptr    <= '0;
                song_len  <= '0;
                full      <= 1'b0;
                recording <= 1'b1;
            end else if (tick) begin
                case (state)
                    ARM: begin
                        if (s_note != NOTE_REST) begin
                            cur_note <= s_note;
                            dur      <= DUR_W'(1);
                            state    <= REC;
                        end
                    end
                    REC: begin
                        if (wr_last) begin
                            full      <= 1'b1;
                            state     <= DONE;
                            recording <= 1'b0;
                        end else if (wr_en) begin
                            cur_note <= s_note;
                            dur      <= DUR_W'(1);
                        end else begin
                            dur <= dur + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    rec_ram #(.DEPTH(DEPTH), .AW(AW), .W(W)) u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_ptr),
        .wr_data  ({cur_note, dur}),
        .rd_valid (rd_valid),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    assign rd_note = rd_data[W-1:DUR_W];
    assign rd_dur  = rd_data[DUR_W-1:0];

endmodule

// File: tb/tb_note_recorder.sv
// Directed checks of note_recorder: basic take, rests, saturation, full
// buffer, coincident control pulses, reset mid-take and read latency.
module tb_note_recorder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       rec_start;
    logic       rec_stop;
    logic [6:0] key;
    logic [1:0] pitch;
    logic [5:0] rd_addr;
    logic [4:0] rd_note;
    logic [7:0] rd_dur;
    logic [6:0] song_len;
    logic       recording;
    logic       full;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    note_recorder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .rec_start (rec_start),
        .rec_stop  (rec_stop),
        .key       (key),
        .pitch     (pitch),
        .rd_addr   (rd_addr),
        .rd_note   (rd_note),
        .rd_dur    (rd_dur),
        .song_len  (song_len),
        .recording (recording),
        .full      (full)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        rec_start = 1'b1;
        step();
        rec_start = 1'b0;
    endtask

    task automatic pulse_stop();
        rec_stop = 1'b1;
        step();
        rec_stop = 1'b0;
    endtask

    task automatic ticks(input logic [6:0] k, input logic [1:0] p, input int n);
        key   = k;
        pitch = p;
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
        end
        tick = 1'b0;
    endtask

    task automatic check_rd(input string tag, input logic [5:0] a,
                            input logic [4:0] n, input logic [7:0] d);
        rd_addr = a;
        step();
        check({tag, "_note"}, rd_note, n);
        check({tag, "_dur"}, rd_dur, d);
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; rec_start = 1'b0; rec_stop = 1'b0;
        key = '0; pitch = '0; rd_addr = '0;
        step();
        step();
        check("rst_len", song_len, 0);
        check("rst_rec", recording, 0);
        check("rst_full", full, 0);
        check("rst_rd_note", rd_note, 0);
        check("rst_rd_dur", rd_dur, 0);
        rst_n = 1'b1;

        // Basic take
        pulse_start();
        check("basic_armed", recording, 1);
        ticks(7'b0000001, 2'b00, 3);
        ticks(7'b0000100, 2'b10, 2);
        pulse_stop();
        check("basic_len", song_len, 2);
        check("basic_rec", recording, 0);
        check("basic_full", full, 0);
        check_rd("basic_a0", 6'd0, 5'b00_001, 8'd3);
        rd_addr = 6'd1;
        #1;
        check("latency_hold", rd_dur, 3);
        step();
        check("latency_a1_note", rd_note, 5'b10_011);
        check("latency_a1_dur", rd_dur, 2);
        check_rd("basic_a2_oob", 6'd2, 5'b0, 8'd0);

        // Rests, priority, pitch 11 as middle, rests carry pitch 00
        pulse_start();
        ticks(7'b0000000, 2'b10, 2);
        ticks(7'b0001010, 2'b11, 1);
        ticks(7'b0000000, 2'b10, 2);
        ticks(7'b1000000, 2'b01, 1);
        pulse_stop();
        check("rest_len", song_len, 3);
        check_rd("rest_a0", 6'd0, 5'b00_010, 8'd1);
        check_rd("rest_a1", 6'd1, 5'b00_000, 8'd2);
        check_rd("rest_a2", 6'd2, 5'b01_111, 8'd1);

        // Saturation splits a long note
        pulse_start();
        ticks(7'b0010000, 2'b01, 300);
        pulse_stop();
        check("sat_len", song_len, 2);
        check_rd("sat_a0", 6'd0, 5'b01_101, 8'd255);
        check_rd("sat_a1", 6'd1, 5'b01_101, 8'd45);

        // Full buffer
        pulse_start();
        for (int i = 1; i <= 70; i++) begin
            ticks((i % 2 == 1) ? 7'b0000001 : 7'b0000010, 2'b00, 1);
        end
        check("full_len", song_len, 64);
        check("full_flag", full, 1);
        check("full_rec", recording, 0);
        ticks(7'b0000100, 2'b00, 3);
        pulse_stop();
        check("full_len_hold", song_len, 64);
        check_rd("full_a0", 6'd0, 5'b00_001, 8'd1);
        check_rd("full_a63", 6'd63, 5'b00_010, 8'd1);

        // rec_stop coincident with a key-changing tick
        pulse_start();
        ticks(7'b0000001, 2'b00, 2);
        key = 7'b0000100; tick = 1'b1; rec_stop = 1'b1;
        step();
        tick = 1'b0; rec_stop = 1'b0;
        check("coinc_len", song_len, 1);
        check("coinc_full", full, 0);
        check_rd("coinc_a0", 6'd0, 5'b00_001, 8'd2);

        // rec_start and rec_stop together in IDLE
        do_reset();
        rec_start = 1'b1; rec_stop = 1'b1;
        step();
        rec_start = 1'b0; rec_stop = 1'b0;
        check("ss_rec", recording, 0);
        ticks(7'b0000001, 2'b00, 2);
        check("ss_rec_after", recording, 0);

        // Reset in the middle of a take
        pulse_start();
        ticks(7'b0000001, 2'b00, 3);
        check("mid_recording", recording, 1);
        do_reset();
        check("mid_len", song_len, 0);
        check("mid_rec", recording, 0);
        check("mid_full", full, 0);
        check_rd("mid_a0", 6'd0, 5'b0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/note_recorder.md
Name: note_recorder

Overview:
- Captures what the player performs on the key switches in manual mode as a time-stamped note sequence in a small on-chip buffer.
- Exposes the stored sequence through a registered read port, so the auto-play path can replay it as a user song.
- It is the writer side of the song-memory interface the player reads: it turns key/pitch input into {note, duration} entries, where the player turns entries into tones.

Parameters:
- DEPTH, 64, number of {note, duration} entries in the buffer.
- AW, 6, address width, equal to log2(DEPTH).
- DUR_W, 8, duration field width in ticks; saturating.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- tick  in  1  one-cycle time-base pulse from an external divider; all key sampling happens only on tick.
- rec_start  in  1  one-cycle pulse that clears the buffer and arms recording.
- rec_stop  in  1  one-cycle pulse that ends recording.
- key  in  7  key switches; bit 0 = do … bit 6 = si.
- pitch  in  2  01 = low, 00 = middle, 10 = high; 11 is treated as 00.
- rd_addr  in  AW  player read address.
- rd_note  out  5  note at rd_addr: {pitch[1:0], idx[2:0]}; idx 1..7 = do..si, idx 0 = rest.
- rd_dur  out  DUR_W  duration in ticks at rd_addr.
- song_len  out  AW+1  number of valid entries.
- recording  out  1  high in ARM or REC.
- full  out  1  buffer filled during the last recording.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - state goes to IDLE.
  - song_len, rd_note, rd_dur, recording and full go to 0.
  - Internal cur_note, dur and wr_ptr go to 0.
  - RAM contents are not cleared; song_len = 0 invalidates them.
  - Reset mid-recording discards the take.
- Note sampling, only on cycles where tick = 1:
  - idx = lowest set bit of key, plus 1; 0 if no key is set.
  - The note pitch field is 00 when idx = 0.
- States: IDLE, ARM, REC, DONE.
- rec_start (any state except during reset):
  - wr_ptr, song_len and full go to 0; next state is ARM.
  - If rec_start and rec_stop arrive in the same cycle, rec_stop wins and rec_start is ignored.
- ARM:
  - On a tick whose sampled note ≠ rest: cur_note = note, dur = 1, go to REC.
  - Leading rests are never stored.
  - rec_stop: go to DONE with song_len = 0.
- REC, on a tick, with s = sampled note:
  - s == cur_note and dur < 2^DUR_W−1: dur increments.
  - s == cur_note and dur saturated: write {cur_note, dur}; dur = 1. Long notes split into consecutive entries.
  - s ≠ cur_note (rests included): write {cur_note, dur}; cur_note = s, dur = 1.
- Write rules:
  - Each write goes to wr_ptr; wr_ptr and song_len increment in the same cycle.
  - If the write lands at index DEPTH−1: full = 1, go to DONE, and the new cur_note is discarded.
- rec_stop in REC:
  - If cur_note ≠ rest, write the final entry. A trailing rest is dropped.
  - Go to DONE.
  - rec_stop takes priority over a coincident tick; that tick is not sampled.
- DONE: holds song_len; only rec_start leaves it.
- Read port:
  - Registered, 1-cycle latency: rd_note/rd_dur reflect the rd_addr sampled at the previous edge.
  - rd_addr ≥ song_len returns 0/0.
  - A read of the address being written in the same cycle returns the old contents (read-first).
- Write and read are independent and legal in every state.

Decomposition:
- Shared package piano_pkg:
  - NOTE_REST = 5'b0.
  - Pitch codes PITCH_LOW = 2'b01, PITCH_MID = 2'b00, PITCH_HIGH = 2'b10.
  - Note-field layout.
  - rec_state_t enum {IDLE, ARM, REC, DONE}.
- Sub-module rec_ram: 1-write/1-read synchronous RAM, DEPTH × (5 + DUR_W), read-first.
- Key-to-note priority encoding stays inline in note_recorder.

Test Plan:
- Basic take:
  - Stimulus: rec_start; key = 0000001, pitch = 00 for 3 ticks; key = 0000100, pitch = 10 for 2 ticks; then rec_stop.
  - Required: song_len = 2; addr 0 → note 5'b00_001, dur 3; addr 1 → note 5'b10_011, dur 2.
- Rests and priority:
  - Stimulus: 2 ticks of key = 0 after rec_start; then key = 0001010 for 1 tick; then key = 0 for 2 ticks; then a key for 1 tick; then rec_stop.
  - Required: no leading rest stored; entries {00_010, 1}, {00_000, 2}, {key, 1}; song_len = 3.
- Saturation:
  - Stimulus: one key held for 300 ticks, then rec_stop.
  - Required: entries {n, 255}, {n, 45}; song_len = 2.
- Full:
  - Stimulus: alternate two keys every tick for 70 ticks.
  - Required: song_len = 64; full = 1; state DONE; recording = 0; further ticks cause no writes.
- Coincident events:
  - Stimulus: rec_stop on the same cycle as a tick that changes the key.
  - Required: final entry keeps the old note and old dur; the tick is ignored.
  - Stimulus: rec_start and rec_stop on the same cycle in IDLE.
  - Required: stays out of ARM.
- Reset mid-REC and read latency:
  - Stimulus: assert rst_n = 0 during REC.
  - Required: song_len = 0, recording = 0; any rd_addr returns 0/0 one cycle later.
